// File: rtl/multiplicador_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_e    : control FSM state encoding (3 bits)
//   cnt_width  : bit width of the iteration counter for a given operand width
package multiplicador_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEval  = 3'd1,
    StAdd   = 3'd2,
    StShift = 3'd3,
    StFix   = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Counter must hold the value WIDTH itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multiplicador_param_dp.sv
// Datapath of the shift-and-add multiplier: M/Q/A/cnt/neg registers, adder,
// shifter, operand abs and result negation.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   load/add/shift/fix: one-hot control strobes from the FSM
//   signed_mode       : operand interpretation, sampled with load
//   a_in, b_in        : operands, sampled with load
//   q0                : current LSB of Q (decides ADD vs SHIFT)
//   last              : the shift in progress is the final iteration
//   product           : 2*WIDTH result register, updated only by fix
module multiplicador_param_dp
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 add,
  input  logic                 shift,
  input  logic                 fix,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 q0,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH:0]     a_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] mag;

  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign a_neg = signed_mode & a_in[WIDTH-1];
  assign b_neg = signed_mode & b_in[WIDTH-1];
  assign a_abs = a_neg ? -a_in : a_in;
  assign b_abs = b_neg ? -b_in : b_in;

  assign mag     = {a_q[WIDTH-1:0], q_q};
  assign q0      = q_q[0];
  assign last    = (cnt_q == CntW'(1));
  assign product = product_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      q_q       <= '0;
      a_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (load) begin
        m_q   <= a_abs;
        q_q   <= b_abs;
        a_q   <= '0;
        cnt_q <= CntW'(WIDTH);
        neg_q <= a_neg ^ b_neg;
      end else if (add) begin
        a_q <= a_q + {1'b0, m_q};
      end else if (shift) begin
        // Carry bit A[WIDTH] drops into A[WIDTH-1]; A[0] moves into Q.
        a_q   <= {1'b0, a_q[WIDTH:1]};
        q_q   <= {a_q[0], q_q[WIDTH-1:1]};
        cnt_q <= cnt_q - 1'b1;
      end
      if (fix) begin
        product_q <= neg_q ? -mag : mag;
      end
    end
  end

endmodule

// File: rtl/multiplicador_param.sv
// Sequential shift-and-add multiplier with signed/unsigned mode and a level
// start/done handshake. The FSM here drives strobes into the datapath.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request (accepted in IDLE, released in DONE)
//   signed_mode : 1 = two's-complement operands
//   a_in, b_in  : operands, captured when start is accepted
//   busy        : operation in progress
//   done        : result valid, held until start drops
//   product     : last result, 2*WIDTH bits
module multiplicador_param
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e state_q;
  state_e state_d;

  logic load;
  logic add;
  logic shift;
  logic fix;
  logic q0;
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StEval;
      StEval:  state_d = q0 ? StAdd : StShift;
      StAdd:   state_d = StShift;
      StShift: state_d = last ? StFix : StEval;
      StFix:   state_d = StDone;
      StDone:  if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    fix   = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle:  load = start;
      StEval:  busy = 1'b1;
      StAdd:   begin busy = 1'b1; add = 1'b1; end
      StShift: begin busy = 1'b1; shift = 1'b1; end
      StFix:   begin busy = 1'b1; fix = 1'b1; end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  multiplicador_param_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .add        (add),
    .shift      (shift),
    .fix        (fix),
    .signed_mode(signed_mode),
    .a_in       (a_in),
    .b_in       (b_in),
    .q0         (q0),
    .last       (last),
    .product    (product)
  );

endmodule

// File: tb/tb_multiplicador_param.sv
// Self-checking bench for multiplicador_param (WIDTH=8 and WIDTH=4 instances).
module tb_multiplicador_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start4 = 1'b0;
  logic        signed_mode4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multiplicador_param #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signed_mode),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  multiplicador_param #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .signed_mode(signed_mode4),
    .a_in       (a4),
    .b_in       (b4),
    .busy       (busy4),
    .done       (done4),
    .product    (product4)
  );

  // Reference: plain integer multiply, truncated to 2*WIDTH bits.
  function automatic logic [15:0] ref_prod8(input logic [7:0] a, input logic [7:0] b,
                                            input logic m);
    int pa;
    int pb;
    int p;
    pa = m ? int'($signed(a)) : int'(a);
    pb = m ? int'($signed(b)) : int'(b);
    p  = pa * pb;
    return 16'(p);
  endfunction

  // Cycles from accepting edge to done: 2W + popcount(|b|) + 1.
  function automatic int ref_lat8(input logic [7:0] b, input logic m);
    int pb;
    pb = m ? int'($signed(b)) : int'(b);
    if (pb < 0) pb = -pb;
    return 2 * 8 + $countones(pb) + 1;
  endfunction

  // One full operation; start and operands are scrambled while busy to show they are ignored.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input string name);
    logic [15:0] exp_p;
    int          exp_lat;
    int          cycles;
    int          busy_cnt;
    exp_p   = ref_prod8(a, b, m);
    exp_lat = ref_lat8(b, m);
    @(negedge clk);
    a_in = a; b_in = b; signed_mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    cycles = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 100) begin
      start = 1'($urandom);
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      signed_mode = 1'($urandom);
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    n_checks++;
    if (cycles !== exp_lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d, expected %0d", name, cycles, exp_lat);
    end
    n_checks++;
    if (product !== exp_p) begin
      n_errors++;
      $display("FAIL %s product: got %h, expected %h", name, product, exp_p);
    end
    n_checks++;
    if (busy_cnt !== exp_lat || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy: high %0d cycles (busy now %b), expected %0d then 0",
               name, busy_cnt, busy, exp_lat);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || product !== exp_p) begin
      n_errors++;
      $display("FAIL %s idle_hold: done=%b product=%h, expected done=0 product=%h",
               name, done, product, exp_p);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset8: busy=%b done=%b product=%h, expected 0/0/0000", busy, done, product);
    end
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'h00) begin
      n_errors++;
      $display("FAIL reset4: busy=%b done=%b product=%h, expected 0/0/00", busy4, done4, product4);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(8'd13,  8'd11,  1'b0, "u13x11");
    run_op(8'hFD,  8'd5,   1'b1, "s-3x5");
    run_op(8'd5,   8'hFD,  1'b1, "s5x-3");
    run_op(8'd255, 8'd255, 1'b0, "u255x255");
    run_op(8'h80,  8'h80,  1'b1, "s-128x-128");
    run_op(8'h80,  8'd127, 1'b1, "s-128x127");
    run_op(8'd200, 8'd0,   1'b0, "u200x0");
    run_op(8'd0,   8'h85,  1'b1, "s0xneg");
  endtask

  task automatic test_width4();
    int cycles;
    @(negedge clk);
    a4 = 4'h8; b4 = 4'd7; signed_mode4 = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    cycles = 0;
    while (!done4 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    n_checks++;
    if (cycles !== 12) begin
      n_errors++;
      $display("FAIL w4 latency: got %0d, expected 12", cycles);
    end
    n_checks++;
    if (product4 !== 8'hC8) begin
      n_errors++;
      $display("FAIL w4 product: got %h, expected c8", product4);
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_handshake();
    int cycles;
    @(negedge clk);
    a_in = 8'd37; b_in = 8'd9; signed_mode = 1'b0; start = 1'b1;
    cycles = 0;
    @(posedge clk);
    #1;
    while (!done && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || product !== 16'd333) begin
        n_errors++;
        $display("FAIL hold_done[%0d]: done=%b busy=%b product=%h, expected 1/0/%h",
                 i, done, busy, product, 16'd333);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL release: done=%b busy=%b, expected 0/0", done, busy);
    end
    run_op(8'd21, 8'hF0, 1'b1, "reassert");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_in = 8'd99; b_in = 8'd77; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      n_errors++;
      $display("FAIL mid_reset: busy=%b done=%b product=%h, expected 0/0/0000",
               busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'hE7, 8'd6, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_width4();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
